// File: rtl/sg_1001001001_pkg.sv
// Shared definitions for the 1001001001 serial link (generator and detector).
// Holds the FSM state encoding, the default pattern and the default widths.
package sg_1001001001_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned    SG_LEN     = 10;
  localparam logic [SG_LEN-1:0] SG_PATTERN = 10'b1001001001;
  localparam int unsigned    SG_CNTW    = 4;
  localparam int unsigned    SG_GAPW    = 4;

endpackage

// File: rtl/sg_1001001001_if.sv
// Control/serial bundle of the pattern generator.
//   start/reps/gap/abort : requests toward the generator
//   x/x_vld/busy/done    : serial output and status from the generator
// master = stimulus side, slave = generator side.
interface sg_1001001001_if #(
  parameter int unsigned CNTW = sg_1001001001_pkg::SG_CNTW,
  parameter int unsigned GAPW = sg_1001001001_pkg::SG_GAPW
);
  logic            start;
  logic [CNTW-1:0] reps;
  logic [GAPW-1:0] gap;
  logic            abort;
  logic            x;
  logic            x_vld;
  logic            busy;
  logic            done;

  modport master (
    output start, reps, gap, abort,
    input  x, x_vld, busy, done
  );

  modport slave (
    input  start, reps, gap, abort,
    output x, x_vld, busy, done
  );
endinterface

// File: rtl/sg_down_cnt.sv
// Loadable down-counter with zero flag.
//   i_clk, i_rst : clock, async active-high reset (clears to 0)
//   i_load/i_din : load value (has priority over i_en)
//   i_en         : decrement by one
//   o_q, o_zero  : current count, count == 0
module sg_down_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q,
  output logic         o_zero
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_en) begin
      r_q <= r_q - W'(1);
    end
  end

  assign o_q    = r_q;
  assign o_zero = (r_q == '0);

endmodule

// File: rtl/sg_1001001001.sv
// Serial pattern generator: sends PATTERN MSB-first, reps times, with gap
// idle cycles between copies.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of sg_1001001001_if
//              (start/reps/gap/abort in; x/x_vld/busy/done out, all registered)
module sg_1001001001
  import sg_1001001001_pkg::*;
#(
  parameter int unsigned     LEN     = SG_LEN,
  parameter logic [LEN-1:0]  PATTERN = SG_PATTERN,
  parameter int unsigned     CNTW    = SG_CNTW,
  parameter int unsigned     GAPW    = SG_GAPW
) (
  input  logic               clk,
  input  logic               rst,
  sg_1001001001_if.slave     bus
);

  localparam int unsigned IDXW = (LEN > 1) ? $clog2(LEN) : 1;

  state_t          r_state;
  logic            r_x;
  logic            r_vld;
  logic            r_busy;
  logic            r_done;
  logic [GAPW-1:0] r_gap_l;

  logic [IDXW-1:0] w_idx_q;
  logic [IDXW-1:0] w_idx_nxt;
  logic            w_idx_zero;
  logic [CNTW-1:0] w_cpy_q;
  logic            w_cpy_zero;
  logic [GAPW-1:0] w_gap_q;
  logic            w_gap_zero;
  logic            w_unused;

  logic w_accept;
  logic w_shift;
  logic w_in_gap;
  logic w_more;

  assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.abort && (bus.reps != '0);
  assign w_shift   = (r_state == ST_SHIFT) && !bus.abort;
  assign w_in_gap  = (r_state == ST_GAP) && !bus.abort;
  // Last bit of a copy with further copies still owed.
  assign w_more    = w_shift && w_idx_zero && !w_cpy_zero;
  assign w_idx_nxt = w_idx_q - IDXW'(1);
  assign w_unused  = ^{w_cpy_q, w_gap_q};

  // Bit index is reloaded at the end of every non-final copy, even when a gap
  // follows; it simply holds at LEN-1 through GAP.
  sg_down_cnt #(.W(IDXW)) u_idx (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_accept || w_more),
    .i_en   (w_shift && !w_idx_zero),
    .i_din  (IDXW'(LEN - 1)),
    .o_q    (w_idx_q),
    .o_zero (w_idx_zero)
  );

  // Copies remaining after the one currently on the line.
  sg_down_cnt #(.W(CNTW)) u_cpy (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_accept),
    .i_en   (w_more),
    .i_din  (bus.reps - CNTW'(1)),
    .o_q    (w_cpy_q),
    .o_zero (w_cpy_zero)
  );

  // Loaded with gap-1 so the zero flag marks the final idle cycle.
  sg_down_cnt #(.W(GAPW)) u_gap (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_more && (r_gap_l != '0)),
    .i_en   (w_in_gap && !w_gap_zero),
    .i_din  (r_gap_l - GAPW'(1)),
    .o_q    (w_gap_q),
    .o_zero (w_gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gap_l <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state <= ST_IDLE;
        r_x     <= 1'b0;
        r_vld   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              if (bus.reps != '0) begin
                r_gap_l <= bus.gap;
                r_state <= ST_SHIFT;
                r_x     <= PATTERN[LEN-1];
                r_vld   <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_done  <= 1'b1;
              end
            end
          end
          ST_SHIFT: begin
            if (!w_idx_zero) begin
              r_x <= PATTERN[w_idx_nxt];
            end else if (w_cpy_zero) begin
              r_state <= ST_IDLE;
              r_x     <= 1'b0;
              r_vld   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_gap_l == '0) begin
              r_x <= PATTERN[LEN-1];
            end else begin
              r_state <= ST_GAP;
              r_x     <= 1'b0;
              r_vld   <= 1'b0;
            end
          end
          ST_GAP: begin
            if (w_gap_zero) begin
              r_state <= ST_SHIFT;
              r_x     <= PATTERN[LEN-1];
              r_vld   <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_x     <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.x     = r_x;
  assign bus.x_vld = r_vld;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_sg_1001001001.sv
// Directed bench for sg_1001001001. Observed word is {x, x_vld, busy, done}.
module tb_sg_1001001001;

  localparam logic [9:0] PAT = 10'b1001001001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sg_1001001001_if #(.CNTW(4), .GAPW(4)) bus ();

  sg_1001001001 #(
    .LEN     (10),
    .PATTERN (10'b1001001001),
    .CNTW    (4),
    .GAPW    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] w_obs;
  assign w_obs = {bus.x, bus.x_vld, bus.busy, bus.done};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered with the MSB of a copy on the line; leaves one cycle after the LSB.
  task automatic chk_copy(input string tag);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s bit%0d", tag, i), {28'd0, w_obs}, {28'd0, PAT[9-i], 3'b110});
      step();
    end
  endtask

  initial begin
    logic [19:0] sh;
    int unsigned busy_cnt;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.reps  = '0;
    bus.gap   = '0;
    bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {28'd0, w_obs}, 32'h0);
    rst = 1'b0;
    step();
    chk("idle after reset", {28'd0, w_obs}, 32'h0);

    // reps=1, gap=0
    bus.reps = 4'd1; bus.gap = 4'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_copy("t1");
    chk("t1 done", {28'd0, w_obs}, 32'h1);
    step();
    chk("t1 idle", {28'd0, w_obs}, 32'h0);

    // reps=3, gap=2; inputs changed while busy must be ignored
    bus.reps = 4'd3; bus.gap = 4'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.reps = 4'd0; bus.gap = 4'd5;
    busy_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("t2 c%0d bit%0d", c, i), {28'd0, w_obs}, {28'd0, PAT[9-i], 3'b110});
        busy_cnt += int'(bus.busy);
        step();
      end
      if (c < 2) begin
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("t2 c%0d gap%0d", c, g), {28'd0, w_obs}, 32'h2);
          busy_cnt += int'(bus.busy);
          step();
        end
      end
    end
    chk("t2 done", {28'd0, w_obs}, 32'h1);
    chk("t2 busy cycles", busy_cnt, 32'd34);
    step();
    chk("t2 idle", {28'd0, w_obs}, 32'h0);

    // reps=2, gap=0: back-to-back copies
    bus.reps = 4'd2; bus.gap = 4'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    sh = '0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t3 vld/busy %0d", i), {29'd0, w_obs[2:0]}, 32'h6);
      sh = {sh[18:0], bus.x};
      step();
    end
    chk("t3 serial", {12'd0, sh}, {12'd0, 20'b10010010011001001001});
    chk("t3 done", {28'd0, w_obs}, 32'h1);
    step();

    // reps=0: done only
    bus.reps = 4'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t4 done", {28'd0, w_obs}, 32'h1);
    step();
    chk("t4 idle a", {28'd0, w_obs}, 32'h0);
    step();
    chk("t4 idle b", {28'd0, w_obs}, 32'h0);

    // abort on 5th SHIFT cycle, then fresh start
    bus.reps = 4'd1; bus.gap = 4'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5 bit%0d", i), {28'd0, w_obs}, {28'd0, PAT[9-i], 3'b110});
      step();
    end
    chk("t5 bit4", {28'd0, w_obs}, {28'd0, PAT[5], 3'b110});
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t5 aborted", {28'd0, w_obs}, 32'h0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_copy("t5 fresh");
    chk("t5 done", {28'd0, w_obs}, 32'h1);
    step();

    // abort and start together in IDLE: abort wins
    bus.abort = 1'b1; bus.start = 1'b1; bus.reps = 4'd1;
    step();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("abort beats start", {28'd0, w_obs}, 32'h0);
    step();
    chk("abort beats start idle", {28'd0, w_obs}, 32'h0);

    // start held high: accepted again in the done cycle
    bus.reps = 4'd1; bus.gap = 4'd0; bus.start = 1'b1;
    step();
    chk_copy("t6 first");
    chk("t6 done", {28'd0, w_obs}, 32'h1);
    step();
    chk("t6 restart msb", {28'd0, w_obs}, 32'he);
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("t6 second bit%0d", i), {28'd0, w_obs}, {28'd0, PAT[9-i], 3'b110});
    end
    step();
    chk("t6 second done", {28'd0, w_obs}, 32'h1);
    step();

    // async reset mid-GAP
    bus.reps = 4'd2; bus.gap = 4'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_copy("t7");
    chk("t7 gap0", {28'd0, w_obs}, 32'h2);
    step();
    chk("t7 gap1", {28'd0, w_obs}, 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t7 async rst", {28'd0, w_obs}, 32'h0);
    #1 rst = 1'b0;
    step();
    chk("t7 idle after rst", {28'd0, w_obs}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
